xor_4b: RTL and testbench
=========================

# xor_4b

Bitwise 4-bit exclusive-OR unit for the 4-bit logic library. Produces a purely combinational result `Y = A ^ B`. Also provides a registered copy of the result plus derived status: Hamming distance, odd parity and an equality flag. It is used as a leaf datapath primitive beside the other 4-bit logic blocks and as a small compare/difference unit.

## Interface
- Parameters: none. Width is fixed at 4 bits through the package constant `XOR_W = 4`.
- `clk`  input  1  single clock; all registered outputs update on its rising edge.
- `rst_n`  input  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `A`  input  4  operand A.
- `B`  input  4  operand B.
- `en`  input  1  capture enable for the registered outputs.
- `Y`  output  4  combinational `A ^ B`.
- `Y_q`  output  4  registered `A ^ B`.
- `hd_q`  output  3  registered Hamming distance, equal to popcount(`A ^ B`), range 0..4.
- `par_q`  output  1  registered XOR-reduction of (`A ^ B`).
- `eq_q`  output  1  registered flag, 1 when `A == B`.
- `vld_q`  output  1  high for the cycle after an enabled capture.

## Operation
- `Y` is pure combinational logic.
  - Bit i of `Y` equals `A[i] ^ B[i]`.
  - `Y` has no dependence on `clk`, `rst_n` or `en`.
  - `Y` is correct even when `clk`, `rst_n` and `en` are left unconnected.
- On each `clk` rising edge:
  - If `rst_n == 0`: `Y_q = 0`, `hd_q = 0`, `par_q = 0`, `eq_q = 1`, `vld_q = 0`.
  - Else if `en == 1`: `Y_q <= A ^ B`, `hd_q <= popcount(A ^ B)`, `par_q <= ^(A ^ B)`, `eq_q <= (A ^ B) == 0`, `vld_q <= 1`.
  - Else: `Y_q`, `hd_q`, `par_q` and `eq_q` hold their values, and `vld_q <= 0`.
- Width rules:
  - `hd_q` is 3 bits so that it can represent 4 without overflow.
  - There is no carry and no sign interpretation.
- `eq_q` and `par_q` are derived from the same XOR vector as `hd_q`. They are always mutually consistent:
  - `eq_q = (hd_q == 0)`.
  - `par_q = hd_q[0]`.

## Timing
- `Y` has zero-cycle latency. It settles in the same simulation timestep as the change on `A` or `B`.
- Registered outputs have one-cycle latency. Values are sampled at edge N and visible after edge N.
- Reset takes priority over `en`.
- If reset is asserted mid-operation, all registered outputs take their reset values at that edge. `Y` keeps tracking `A ^ B`.
- When `en` is held high, a new capture happens every cycle. `vld_q` stays at 1 with no bubbles.

## Structure
- Shared package `logic4_pkg` contains:
  - `XOR_W = 4`.
  - `HD_W = 3`.
  - typedef `nib_t` (4-bit logic).
- Sub-module `popcount4`: combinational 4-bit input, 3-bit count output. It is instantiated once on `A ^ B`.
- Everything else sits in the top module: XOR array, reduction, and one register stage.

## Test plan
- `A=1100`, `B=1010` -> `Y=0110` immediately. With `en=1`, after the next edge: `Y_q=0110`, `hd_q=2`, `par_q=0`, `eq_q=0`, `vld_q=1`.
- `A=0011`, `B=0101` -> `Y=0110`, `hd_q=2`, `par_q=0`.
- `A=1111`, `B=0000` -> `Y=1111`, `hd_q=4` (no overflow), `par_q=0`, `eq_q=0`.
- `A=0001`, `B=0011` -> `Y=0010`, `hd_q=1`, `par_q=1`. Then `A=B=1010` -> `Y=0000`, `hd_q=0`, `eq_q=1`.
- Reset and enable gating:
  - Apply `rst_n=0` together with `en=1` and `A=1111`, `B=0000`. After the edge the registered outputs hold the reset values (`Y_q=0`, `eq_q=1`, `vld_q=0`) while `Y=1111`.
  - Then release reset with `en=0` and change the inputs. `Y` follows the inputs, the registered outputs hold, and `vld_q=0`.
- Leave `clk`, `rst_n` and `en` unconnected and step the four vectors above at 10-time-unit intervals. `Y` must match `A ^ B` in every step.

Source files
------------

// File: rtl/logic4_pkg.sv
// Shared constants and types for the 4-bit logic library.
package logic4_pkg;

    // Operand width of every 4-bit logic block.
    localparam int XOR_W = 4;

    // Width of a population count over one operand; must hold the value 4.
    localparam int HD_W = 3;

    // One 4-bit operand.
    typedef logic [XOR_W-1:0] nib_t;

endpackage : logic4_pkg

// File: rtl/popcount4.sv
// Combinational population count of a 4-bit vector (result 0..4).
module popcount4
    import logic4_pkg::*;
(
    input  logic [XOR_W-1:0] v,
    output logic [HD_W-1:0]  cnt
);

    // Sum the set bits of the input vector.
    always_comb begin
        // NOTE: assigning a default before the loop keeps every path driven, so no latch is inferred.
        cnt = '0;
        for (int i = 0; i < XOR_W; i++) begin
            cnt = cnt + HD_W'(v[i]);
        end
    end

endmodule : popcount4

// File: rtl/xor_4b.sv
// Bitwise 4-bit XOR with a combinational result and a registered copy
// carrying Hamming distance, odd parity and an equality flag.
module xor_4b
    import logic4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XOR_W-1:0]  A,
    input  logic [XOR_W-1:0]  B,
    input  logic              en,
    output logic [XOR_W-1:0]  Y,
    output logic [XOR_W-1:0]  Y_q,
    output logic [HD_W-1:0]   hd_q,
    output logic              par_q,
    output logic              eq_q,
    output logic              vld_q
);

    nib_t              diff;
    logic [HD_W-1:0]   hd;
    logic              par;
    logic              eq;

    // XOR array; Y depends on nothing but the two operands.
    assign diff = A ^ B;
    assign Y    = diff;

    // Status derived from the same difference vector, so eq/par/hd always agree.
    assign par = ^diff;
    assign eq  = (diff == '0);

    popcount4 u_popcount4 (
        .v   (diff),
        .cnt (hd)
    );

    // Single register stage: synchronous reset first, then enabled capture.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous, so rst_n stays out of the sensitivity list.
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            Y_q   <= '0;
            hd_q  <= '0;
            par_q <= 1'b0;
            eq_q  <= 1'b1;
            vld_q <= 1'b0;
        end else if (en) begin
            Y_q   <= diff;
            hd_q  <= hd;
            par_q <= par;
            eq_q  <= eq;
            vld_q <= 1'b1;
        end else begin
            vld_q <= 1'b0;
        end
    end

endmodule : xor_4b

// File: tb/tb_xor_4b.sv
// Directed bench for xor_4b: combinational Y checked at drive time,
// registered outputs checked against a queued reference model after each edge.
module tb_xor_4b;
    import logic4_pkg::*;

    typedef struct {
        logic [3:0] y;
        logic [2:0] hd;
        logic       par;
        logic       eq;
        logic       vld;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Y;
    logic [3:0] Y_q;
    logic [2:0] hd_q;
    logic       par_q;
    logic       eq_q;
    logic       vld_q;

    // Second instance whose clock, reset and enable are left floating.
    logic       f_clk   = 1'bz;
    logic       f_rst_n = 1'bz;
    logic       f_en    = 1'bz;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [3:0] fy;
    logic [3:0] fy_q;
    logic [2:0] fhd_q;
    logic       fpar_q;
    logic       feq_q;
    logic       fvld_q;

    int n_cmp = 0;
    int n_err = 0;

    exp_t model;
    exp_t sb[$];

    xor_4b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .en    (en),
        .Y     (Y),
        .Y_q   (Y_q),
        .hd_q  (hd_q),
        .par_q (par_q),
        .eq_q  (eq_q),
        .vld_q (vld_q)
    );

    xor_4b u_float (
        .clk   (f_clk),
        .rst_n (f_rst_n),
        .A     (fa),
        .B     (fb),
        .en    (f_en),
        .Y     (fy),
        .Y_q   (fy_q),
        .hd_q  (fhd_q),
        .par_q (fpar_q),
        .eq_q  (feq_q),
        .vld_q (fvld_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Bench-side Hamming distance, written independently of the RTL adder chain.
    function automatic logic [2:0] ref_hd(input logic [3:0] x);
        case (x)
            4'b0000:                                         return 3'd0;
            4'b0001, 4'b0010, 4'b0100, 4'b1000:              return 3'd1;
            4'b0111, 4'b1011, 4'b1101, 4'b1110:              return 3'd3;
            4'b1111:                                         return 3'd4;
            default:                                         return 3'd2;
        endcase
    endfunction

    // Drive one cycle of stimulus, check Y at once, queue the registered expectation.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic e, input logic r);
        logic [3:0] x;
        exp_t       got;
        A = a; B = b; en = e; rst_n = r;
        x = a ^ b;
        #1;
        check({tag, ".Y"}, Y, x);
        if (!r) begin
            model = '{y: 4'b0000, hd: 3'd0, par: 1'b0, eq: 1'b1, vld: 1'b0};
        end else if (e) begin
            model.y   = x;
            model.hd  = ref_hd(x);
            model.par = (ref_hd(x) == 3'd1) || (ref_hd(x) == 3'd3);
            model.eq  = (a == b);
            model.vld = 1'b1;
        end else begin
            model.vld = 1'b0;
        end
        sb.push_back(model);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 4'd1, 4'd0);
        end else begin
            got = sb.pop_front();
            check({tag, ".Y_q"},   Y_q,           got.y);
            check({tag, ".hd_q"},  {1'b0, hd_q},  {1'b0, got.hd});
            check({tag, ".par_q"}, {3'b0, par_q}, {3'b0, got.par});
            check({tag, ".eq_q"},  {3'b0, eq_q},  {3'b0, got.eq});
            check({tag, ".vld_q"}, {3'b0, vld_q}, {3'b0, got.vld});
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; A = 4'b0000; B = 4'b0000;
        fa = 4'b0000; fb = 4'b0000;
        model = '{y: 4'b0000, hd: 3'd0, par: 1'b0, eq: 1'b1, vld: 1'b0};
        @(posedge clk);
        #1;

        // Reset state
        step("rst",     4'b1111, 4'b0000, 1'b0, 1'b0);
        // Main function
        step("v1100",   4'b1100, 4'b1010, 1'b1, 1'b1);
        step("v0011",   4'b0011, 4'b0101, 1'b1, 1'b1);
        step("v1111",   4'b1111, 4'b0000, 1'b1, 1'b1);
        step("v0001",   4'b0001, 4'b0011, 1'b1, 1'b1);
        step("veq",     4'b1010, 4'b1010, 1'b1, 1'b1);
        step("hold_eq", 4'b0110, 4'b1001, 1'b0, 1'b1);
        step("v0111",   4'b0111, 4'b0000, 1'b1, 1'b1);
        // Reset wins over enable
        step("rst_en",  4'b1111, 4'b0000, 1'b1, 1'b0);
        // Released with enable low: registers hold reset values
        step("hold1",   4'b0110, 4'b0011, 1'b0, 1'b1);
        step("hold2",   4'b1001, 4'b0000, 1'b0, 1'b1);
        step("v0101",   4'b0101, 4'b1010, 1'b1, 1'b1);

        // Floating clk/rst_n/en: Y still tracks A ^ B
        fa = 4'b1100; fb = 4'b1010; #10; check("float1.Y", fy, 4'b0110);
        fa = 4'b0011; fb = 4'b0101; #10; check("float2.Y", fy, 4'b0110);
        fa = 4'b1111; fb = 4'b0000; #10; check("float3.Y", fy, 4'b1111);
        fa = 4'b0001; fb = 4'b0011; #10; check("float4.Y", fy, 4'b0010);
        fa = 4'b1010; fb = 4'b1010; #10; check("float5.Y", fy, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_xor_4b
